// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the load/store port, one request at a time,
// RV32 byte/half/word access after WAIT_STATES wait cycles. Optional MMIO register: DMEM_MMIO_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mmio_out
);

  localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   wdata_rep;
  logic [3:0]    be;
  logic          legal_f3;
  logic          misaligned;
  logic          in_range;
  logic          acc_err;
  logic [31:0]   acc_rdata;
  logic          mem_wr;
  logic          fire;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign fire     = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign word_idx = addr_q[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign in_range = ({1'b0, addr_q} < BYTE_LIMIT);
  assign byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  // Legality, alignment and lane steering of the latched request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    load_val   = '0;
    wdata_rep  = '0;
    be         = '0;
    if (we_q) begin
      legal_f3 = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
    end else begin
      legal_f3 = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                 (funct3_q == 3'b100) || (funct3_q == 3'b101);
    end
    case (funct3_q[1:0])
      2'b00: begin
        wdata_rep = {4{wdata_q[7:0]}};
        be        = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        misaligned = addr_q[0];
        wdata_rep  = {2{wdata_q[15:0]}};
        be         = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        misaligned = (addr_q[1:0] != 2'b00);
        wdata_rep  = wdata_q;
        be         = 4'b1111;
      end
      default: ;
    endcase
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase
  end

`ifdef DMEM_MMIO_EN
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  logic [31:0] mmio_q;
  logic        mmio_wr;

  always_comb begin
    acc_err   = !legal_f3 || misaligned || !in_range;
    acc_rdata = we_q ? '0 : load_val;
    mem_wr    = !acc_err && we_q;
    mmio_wr   = 1'b0;
    // The MMIO word bypasses the range check; only full-word access is legal there.
    if (addr_q == MMIO_ADDR) begin
      acc_err   = (funct3_q != 3'b010);
      mem_wr    = 1'b0;
      mmio_wr   = !acc_err && we_q;
      acc_rdata = we_q ? '0 : mmio_q;
    end
    if (acc_err) acc_rdata = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_q <= '0;
    end else if (fire && mmio_wr) begin
      mmio_q <= wdata_q;
    end
  end

  assign mmio_out = mmio_q;
`else
  always_comb begin
    acc_err   = !legal_f3 || misaligned || !in_range;
    acc_rdata = (we_q || acc_err) ? '0 : load_val;
    mem_wr    = !acc_err && we_q;
  end

  assign mmio_out = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_STATES[3:0];
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = acc_rdata;
          err_d   = acc_err;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Writes land only on the WAIT-to-RESP edge; reset returns the FSM to IDLE, which blocks them.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset so it maps onto RAM; its contents survive rst.
    if (fire && mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven transactions plus hand-written
// backpressure and reset sequences. Expectations follow DMEM_MMIO_EN when defined.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mmio_out;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mmio_out   (mmio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request for the accepting edge, then scramble the ignored inputs.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                          output int lat);
    send(we, f3, addr, wdata);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    consume();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stable;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

    #2;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err",   32'(rsp_err), 32'd0);
    check("reset_mmio_out",  mmio_out, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // we, funct3, addr, wdata, expected rdata, expected err
    add_vec(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add_vec(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add_vec(1, 3'b000, 32'h11,  32'h000000AA, 32'h0,        0);
    add_vec(0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 0);
    add_vec(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFAA, 0);
    add_vec(0, 3'b100, 32'h11,  32'h0,        32'h000000AA, 0);
    add_vec(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0);
    add_vec(0, 3'b001, 32'h13,  32'h0,        32'h0,        1);
    add_vec(1, 3'b010, 32'h12,  32'h12345678, 32'h0,        1);
    add_vec(0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 0);
    add_vec(0, 3'b010, DEPTH*4, 32'h0,        32'h0,        1);
    add_vec(1, 3'b010, 32'h14,  32'h11223344, 32'h0,        0);
    add_vec(1, 3'b001, 32'h16,  32'h1234BEEF, 32'h0,        0);
    add_vec(0, 3'b010, 32'h14,  32'h0,        32'hBEEF3344, 0);
    add_vec(0, 3'b001, 32'h16,  32'h0,        32'hFFFFBEEF, 0);
    add_vec(0, 3'b001, 32'h14,  32'h0,        32'h00003344, 0);
    add_vec(0, 3'b000, 32'h14,  32'h0,        32'h00000044, 0);
    add_vec(1, 3'b000, 32'h17,  32'hFFFFFF80, 32'h0,        0);
    add_vec(0, 3'b010, 32'h14,  32'h0,        32'h80EF3344, 0);
    add_vec(0, 3'b000, 32'h17,  32'h0,        32'hFFFFFF80, 0);
    add_vec(0, 3'b011, 32'h10,  32'h0,        32'h0,        1);
    add_vec(0, 3'b110, 32'h10,  32'h0,        32'h0,        1);
    add_vec(1, 3'b100, 32'h10,  32'h0,        32'h0,        1);
    add_vec(1, 3'b001, 32'h11,  32'h0000FFFF, 32'h0,        1);
    add_vec(0, 3'b010, 32'h12,  32'h0,        32'h0,        1);
    add_vec(0, 3'b010, 32'h10,  32'h0,        32'hDEADAAEF, 0);
    add_vec(1, 3'b010, DEPTH*4-4, 32'hA5A50F0F, 32'h0,      0);
    add_vec(0, 3'b010, DEPTH*4-4, 32'h0,      32'hA5A50F0F, 0);
    add_vec(0, 3'b000, 32'hFFFFFFF0, 32'h0,   32'h0,        1);
`ifdef DMEM_MMIO_EN
    add_vec(1, 3'b010, 32'hFFFFFFF0, 32'hCAFE0001, 32'h0,        0);
    add_vec(0, 3'b010, 32'hFFFFFFF0, 32'h0,        32'hCAFE0001, 0);
    add_vec(1, 3'b000, 32'hFFFFFFF0, 32'h00000077, 32'h0,        1);
    add_vec(0, 3'b100, 32'hFFFFFFF0, 32'h0,        32'h0,        1);
    add_vec(0, 3'b010, 32'hFFFFFFF0, 32'h0,        32'hCAFE0001, 0);
`else
    add_vec(1, 3'b010, 32'hFFFFFFF0, 32'hCAFE0001, 32'h0,        1);
    add_vec(0, 3'b010, 32'hFFFFFFF0, 32'h0,        32'h0,        1);
    add_vec(1, 3'b000, 32'hFFFFFFF0, 32'h00000077, 32'h0,        1);
`endif

    foreach (vecs[i]) begin
      transact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(WS + 1));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ready_after", i), 32'(req_ready), 32'd1);
    end

`ifdef DMEM_MMIO_EN
    check("mmio_out_value", mmio_out, 32'hCAFE0001);
`else
    check("mmio_out_value", mmio_out, 32'h0);
`endif

    // Backpressure: response held for 5 cycles while a competing store is offered.
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'(WS + 1));
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    stable = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1 && rsp_rdata === 32'hDEADAAEF && rsp_err === 1'b0 && req_ready === 1'b0)
        stable++;
    end
    check("bp_stable_cycles", 32'(stable), 32'd5);
    consume();
    req_valid = 1'b0;
    check("bp_released_valid", 32'(rsp_valid), 32'd0);
    check("bp_released_ready", 32'(req_ready), 32'd1);
    transact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'hDEADAAEF);

    // Reset while in WAIT with the counter at zero: the store must not commit.
    transact(1'b1, 3'b010, 32'h20, 32'h77777777, rd, er, lat);
    transact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    check("rst_prior_value", rd, 32'h77777777);
    send(1'b1, 3'b010, 32'h20, 32'h00000055);
    repeat (WS) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_rsp_rdata", rsp_rdata, 32'd0);
    check("rstw_rsp_err",   32'(rsp_err), 32'd0);
    check("rstw_mmio_out",  mmio_out, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    transact(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    check("rstw_no_write", rd, 32'h77777777);
    check("rstw_no_write_err", 32'(er), 32'd0);

    // Reset while a response is pending discards it.
    send(1'b0, 3'b010, 32'h10, 32'h0);
    wait_rsp(lat);
    check("rstr_valid_before", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rstr_valid_during", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstr_valid_after", 32'(rsp_valid), 32'd0);
    check("rstr_ready_after", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the pipeline's load/store port.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs RV32 byte, halfword or word access with little-endian lane steering and load sign/zero extension.
- Returns a response (read data plus error flag) after a configurable number of wait states. Replaces the single-cycle data RAM behind the MEM stage.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage; byte range is 0 to DEPTH_WORDS*4-1.
- WAIT_STATES, 1: extra cycles between request acceptance and access; legal range 0..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 load/store funct3.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load result, extended; 0 for stores and errors.
- rsp_err  output  1  misaligned, out-of-range or illegal funct3.
- mmio_out  output  32  MMIO register (see Optional Feature).

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mmio_out=0, state IDLE, wait counter 0.
- Storage array is not reset.
- States:
  - IDLE: req_ready=1. When req_valid is high, latch we/funct3/addr/wdata, load counter with WAIT_STATES, go to WAIT.
  - WAIT: req_ready=0. If counter != 0, decrement. If counter == 0: perform the access, register rdata and err, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rdata and err are held stable until rsp_ready is high; on that edge go to IDLE with rsp_valid=0.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one request per WAIT_STATES+3 cycles.
- No new request can be accepted in the cycle a response is consumed.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else sets err=1.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Violations set err=1.
- Range: addr >= DEPTH_WORDS*4 sets err=1. Word index is addr[log2(DEPTH_WORDS)+1:2].
- On error: no storage write, rdata=0.
- Store write: byte enables come from funct3 and addr[1:0]. Data is replicated to the selected lanes: byte to lane addr[1:0], halfword to lanes {addr[1],0} and {addr[1],1}. Unselected bytes are unchanged.
- Load read: select the lane(s), then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- The write is committed only on the WAIT-to-RESP edge. Reset asserted in IDLE or WAIT drops the request with no write. Reset in RESP discards the pending response.
- Request inputs are ignored outside IDLE. The requester must hold them only until acceptance.

Optional Feature:
- Macro DMEM_MMIO_EN.
- When defined:
  - A word store (SW) to address 0xFFFF_FFF0 is not range-checked. It updates mmio_out with wdata on the WAIT-to-RESP edge and returns err=0.
  - LW from 0xFFFF_FFF0 returns mmio_out.
  - Byte or halfword access to this address returns err=1.
- When undefined: mmio_out is tied to 0 and 0xFFFF_FFF0 is an ordinary out-of-range address (err=1).

Test Plan:
- Run with WAIT_STATES=1. SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> rdata 0xDEADBEEF, err=0. rsp_valid rises exactly 2 cycles after each acceptance.
- After the above: SB addr 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF. LB 0x11 -> 0xFFFFFFAA. LBU 0x11 -> 0x000000AA. LHU 0x12 -> 0x0000DEAD.
- LH addr 0x13 -> err=1, rdata=0. SW addr 0x12 data 0x12345678 -> err=1, and a following LW 0x10 is unchanged. LW addr DEPTH_WORDS*4 -> err=1.
- Response backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid/rdata/err stay stable and req_ready=0 throughout. The response is released on the first rsp_ready=1 edge.
- Reset mid-operation: accept SW 0x20 data 0x55; assert rst while in WAIT (WAIT_STATES=3). After reset, LW 0x20 returns the prior contents, and outputs equal their reset values during reset.
- With DMEM_MMIO_EN: SW 0xFFFFFFF0 data 0xCAFE0001 -> mmio_out=0xCAFE0001, err=0. LW 0xFFFFFFF0 -> 0xCAFE0001. SB same address -> err=1. Without the macro, the same SW -> err=1 and mmio_out stays 0.
